// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one outstanding word fetch at a time, buffers returned
// instructions with their PCs in a small FIFO and presents decoded fields.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [5:0]  funct,
  output logic [25:0] instr_address,
  output logic [14:0] Adress_Immediate,
  output logic [1:0]  InstructionType,
  output logic [31:0] pc,
  output logic        halted
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_HALTED  = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      instr_mem [FIFO_DEPTH];
  logic [31:0]      pc_mem    [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_after_deq;
  logic             enq, deq;
  logic [31:0]      head_instr;
  logic             redirect_low_unused;

  // Redirect targets are word aligned; the low bits are dropped.
  assign redirect_low_unused = ^redirect_pc[1:0];

  assign out_valid = (count_reg != '0);
  assign imem_addr = fetch_pc_reg;
  assign halted    = (state_reg == S_HALTED);

  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    imem_req        = 1'b0;
    enq             = 1'b0;
    deq             = out_valid && out_ready && !redirect_valid;
    count_after_deq = count_reg - {{(CNT_W-1){1'b0}}, deq};
    case (state_reg)
      S_FETCH: begin
        // Gated by rst_n so no request is shown while reset is held.
        if (rst_n && !redirect_valid && (count_after_deq < DEPTH_C)) begin
          imem_req   = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_valid) begin
          if (redirect_valid) begin
            state_next = S_FETCH;
          end else begin
            enq           = 1'b1;
            fetch_pc_next = fetch_pc_reg + 32'd4;
            state_next    = (imem_rdata[31:26] == OP_HALT) ? S_HALTED : S_FETCH;
          end
        end else if (redirect_valid) begin
          state_next = S_DISCARD;
        end
      end
      S_HALTED: begin
        if (redirect_valid) state_next = S_FETCH;
      end
      S_DISCARD: begin
        // The stale response is the only thing outstanding; once it lands we refetch.
        if (imem_valid) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
    if (redirect_valid) fetch_pc_next = {redirect_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      fetch_pc_reg <= RESET_PC;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if (redirect_valid) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (enq) begin
          instr_mem[wr_ptr_reg] <= imem_rdata;
          pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
          wr_ptr_reg            <= wr_ptr_reg + PTR_W'(1);
        end
        if (deq) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_after_deq + {{(CNT_W-1){1'b0}}, enq};
      end
    end
  end

  assign head_instr       = instr_mem[rd_ptr_reg];
  assign pc               = pc_mem[rd_ptr_reg];
  assign opcode           = head_instr[31:26];
  assign rs               = head_instr[25:21];
  assign rt               = head_instr[20:16];
  assign rd               = head_instr[15:11];
  assign sa               = head_instr[10:6];
  assign funct            = head_instr[5:0];
  assign instr_address    = head_instr[25:0];
  assign Adress_Immediate = head_instr[14:0];

  always_comb begin
    InstructionType = 2'd3;
    case (opcode)
      6'b000000:          InstructionType = 2'd0;
      6'b000010, 6'b000011: InstructionType = 2'd1;
      OP_HALT:            InstructionType = 2'd2;
      default:            InstructionType = 2'd3;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a delayed-response memory model plus
// hand-driven responses for the cycle-exact reset and redirect scenarios.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, sa;
  logic [5:0]  funct;
  logic [25:0] instr_address;
  logic [14:0] Adress_Immediate;
  logic [1:0]  InstructionType;
  logic [31:0] pc;
  logic        halted;

  logic        resp_en = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'h0;
  logic        man_valid = 1'b0;
  logic [31:0] man_data = 32'h0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  int          req_cnt = 0;
  logic [31:0] req_log [256];
  int          vec = 0;
  int          errs = 0;

  assign imem_valid = resp_en ? resp_valid : man_valid;
  assign imem_rdata = resp_en ? resp_data  : man_data;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .funct(funct),
    .instr_address(instr_address), .Adress_Immediate(Adress_Immediate),
    .InstructionType(InstructionType), .pc(pc), .halted(halted)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0020;
      32'h0000_0004: return 32'h2001_0005;
      32'h0000_0008: return 32'h0800_0040;
      32'h0000_0040: return 32'h2003_0001;
      32'h0000_0044: return 32'hFC00_0000;
      default:       return {6'b001000, 5'd2, 5'd3, a[15:0]};
    endcase
  endfunction

  // Memory model: sees requests mid-cycle, answers two cycles later.
  always @(negedge clk) begin
    resp_valid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        resp_valid = 1'b1;
        resp_data  = mem_word(pend_addr);
      end
    end
    if (!rst_n) begin
      pend_cnt = 0;
    end else if (imem_req) begin
      req_log[req_cnt % 256] = imem_addr;
      req_cnt = req_cnt + 1;
      if (resp_en) begin
        pend_addr = imem_addr;
        pend_cnt  = 2;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    step();
    rst_n = 1'b0; resp_en = 1'b0; man_valid = 1'b0; man_data = 32'h0;
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vec++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rst_imem_req: got %b expected 0", imem_req); end
    vec++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL rst_imem_addr: got %h expected 00000000", imem_addr); end
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    vec++; if (halted !== 1'b0) begin errs++; $display("FAIL rst_halted: got %b expected 0", halted); end
    vec++; if (pc !== 32'h0) begin errs++; $display("FAIL rst_pc: got %h expected 00000000", pc); end
    vec++; if ({opcode, funct, Adress_Immediate} !== 27'h0) begin errs++; $display("FAIL rst_fields: got %h expected 0", {opcode, funct, Adress_Immediate}); end
    vec++; if (InstructionType !== 2'd0) begin errs++; $display("FAIL rst_type: got %0d expected 0", InstructionType); end
    rst_n = 1'b1;
    #1;
    vec++; if (imem_req !== 1'b1) begin errs++; $display("FAIL rel_imem_req: got %b expected 1", imem_req); end
    $display("reset: released, first request addr=%h", imem_addr);
  endtask

  task automatic test_stream();
    int got;
    int req_start;
    logic [31:0] exp_pc [3];
    logic [1:0]  exp_ty [3];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    exp_ty[0] = 2'd0;  exp_ty[1] = 2'd3;  exp_ty[2] = 2'd1;
    apply_reset();
    req_start = req_cnt;
    resp_en = 1'b1; out_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 60 && got < 3; n++) begin
      step();
      if (out_valid) begin
        $display("stream: deliver pc=%h op=%h type=%0d", pc, opcode, InstructionType);
        vec++; if (pc !== exp_pc[got]) begin errs++; $display("FAIL stream_pc%0d: got %h expected %h", got, pc, exp_pc[got]); end
        vec++; if (InstructionType !== exp_ty[got]) begin errs++; $display("FAIL stream_type%0d: got %0d expected %0d", got, InstructionType, exp_ty[got]); end
        if (got == 0) begin
          vec++; if (funct !== 6'h20) begin errs++; $display("FAIL stream_funct: got %h expected 20", funct); end
        end else if (got == 1) begin
          vec++; if (Adress_Immediate !== 15'h0005) begin errs++; $display("FAIL stream_imm: got %h expected 0005", Adress_Immediate); end
          vec++; if ({rs, rt} !== {5'd0, 5'd1}) begin errs++; $display("FAIL stream_rs_rt: got %h expected 001", {rs, rt}); end
        end else begin
          vec++; if (instr_address !== 26'h40) begin errs++; $display("FAIL stream_jaddr: got %h expected 0000040", instr_address); end
        end
        got++;
      end
    end
    vec++; if (got != 3) begin errs++; $display("FAIL stream_timeout: got %0d words expected 3", got); end
    for (int k = 0; k < 3; k++) begin
      vec++; if (req_log[(req_start + k) % 256] !== exp_pc[k]) begin errs++; $display("FAIL stream_req%0d: got %h expected %h", k, req_log[(req_start + k) % 256], exp_pc[k]); end
    end
  endtask

  task automatic test_backpressure();
    int got;
    int req_start;
    apply_reset();
    req_start = req_cnt;
    resp_en = 1'b1; out_ready = 1'b0;
    repeat (40) step();
    #1;
    $display("backpressure: %0d requests while stalled", req_cnt - req_start);
    vec++; if (req_cnt - req_start != 4) begin errs++; $display("FAIL bp_req_count: got %0d expected 4", req_cnt - req_start); end
    vec++; if (imem_req !== 1'b0) begin errs++; $display("FAIL bp_req_blocked: got %b expected 0", imem_req); end
    vec++; if (pc !== 32'h0) begin errs++; $display("FAIL bp_head_pc: got %h expected 00000000", pc); end
    out_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 40 && got < 5; n++) begin
      if (out_valid) begin
        $display("backpressure: deliver pc=%h", pc);
        vec++; if (pc !== 32'(got * 4)) begin errs++; $display("FAIL bp_order%0d: got %h expected %h", got, pc, 32'(got * 4)); end
        got++;
      end
      step();
    end
    vec++; if (got != 5) begin errs++; $display("FAIL bp_timeout: got %0d words expected 5", got); end
    vec++; if (req_log[(req_start + 4) % 256] !== 32'h10) begin errs++; $display("FAIL bp_resume_addr: got %h expected 00000010", req_log[(req_start + 4) % 256]); end
  endtask

  task automatic test_redirect_wait();
    int req_start;
    int n;
    apply_reset();
    req_start = req_cnt;
    resp_en = 1'b1; out_ready = 1'b0;
    for (n = 0; n < 40 && req_cnt < req_start + 4; n++) step();
    vec++; if (req_cnt < req_start + 4) begin errs++; $display("FAIL rw_fill_timeout: got %0d requests expected 4", req_cnt - req_start); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    vec++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rw_wait_req: got %b expected 0", imem_req); end
    step();
    redirect_valid = 1'b0;
    #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rw_flush: got %b expected 0", out_valid); end
    vec++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rw_discard_req: got %b expected 0", imem_req); end
    for (n = 0; n < 20 && req_cnt < req_start + 5; n++) step();
    vec++; if (req_log[(req_start + 4) % 256] !== 32'h100 || req_cnt < req_start + 5) begin errs++; $display("FAIL rw_new_addr: got %h expected 00000100", req_log[(req_start + 4) % 256]); end
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rw_stale_dropped: got %b expected 0", out_valid); end
    for (n = 0; n < 20 && !out_valid; n++) step();
    $display("redirect_wait: deliver pc=%h imm=%h", pc, Adress_Immediate);
    vec++; if (pc !== 32'h100) begin errs++; $display("FAIL rw_pc: got %h expected 00000100", pc); end
    vec++; if (Adress_Immediate !== 15'h0100) begin errs++; $display("FAIL rw_word: got %h expected 0100", Adress_Immediate); end
  endtask

  task automatic test_halt();
    int req_mark;
    int n;
    apply_reset();
    resp_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    vec++; if (imem_req !== 1'b0) begin errs++; $display("FAIL halt_redir_noreq: got %b expected 0", imem_req); end
    step();
    redirect_valid = 1'b0;
    #1;
    vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errs++; $display("FAIL halt_first_req: got %b/%h expected 1/00000040", imem_req, imem_addr); end
    for (n = 0; n < 40 && !halted; n++) step();
    $display("halt: halted=%b head pc=%h type=%0d", halted, pc, InstructionType);
    vec++; if (halted !== 1'b1) begin errs++; $display("FAIL halt_flag: got %b expected 1", halted); end
    vec++; if (out_valid !== 1'b1 || InstructionType !== 2'd2) begin errs++; $display("FAIL halt_deliver: got %b/%0d expected 1/2", out_valid, InstructionType); end
    vec++; if (pc !== 32'h44) begin errs++; $display("FAIL halt_pc: got %h expected 00000044", pc); end
    req_mark = req_cnt;
    repeat (8) step();
    vec++; if (req_cnt != req_mark || imem_req !== 1'b0) begin errs++; $display("FAIL halt_no_req: got %0d new expected 0", req_cnt - req_mark); end
    vec++; if (out_valid !== 1'b0 || halted !== 1'b1) begin errs++; $display("FAIL halt_drained: got %b/%b expected 0/1", out_valid, halted); end
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0;
    #1;
    vec++; if (halted !== 1'b0) begin errs++; $display("FAIL halt_clear: got %b expected 0", halted); end
    vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errs++; $display("FAIL halt_restart: got %b/%h expected 1/00000200", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid_request();
    apply_reset();
    step();
    man_valid = 1'b1; man_data = 32'h2005_0009;
    step();
    man_valid = 1'b0;
    #1;
    vec++; if (out_valid !== 1'b1 || opcode !== 6'h08) begin errs++; $display("FAIL rm_first: got %b/%h expected 1/08", out_valid, opcode); end
    step();
    #1;
    vec++; if (imem_addr !== 32'h4 || imem_req !== 1'b0) begin errs++; $display("FAIL rm_waiting: got %h/%b expected 00000004/0", imem_addr, imem_req); end
    rst_n = 1'b0;
    #1;
    $display("reset_mid: async reset, out_valid=%b addr=%h", out_valid, imem_addr);
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rm_async_valid: got %b expected 0", out_valid); end
    vec++; if (opcode !== 6'h0 || pc !== 32'h0) begin errs++; $display("FAIL rm_async_fields: got %h/%h expected 00/00000000", opcode, pc); end
    vec++; if (imem_addr !== 32'h0 || imem_req !== 1'b0 || halted !== 1'b0) begin errs++; $display("FAIL rm_async_addr: got %h/%b/%b expected 00000000/0/0", imem_addr, imem_req, halted); end
    step();
    rst_n = 1'b1; man_valid = 1'b1; man_data = 32'hDEAD_BEEF;
    #1;
    vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errs++; $display("FAIL rm_restart: got %b/%h expected 1/00000000", imem_req, imem_addr); end
    step();
    man_valid = 1'b0;
    #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rm_late_ignored: got %b expected 0", out_valid); end
    man_valid = 1'b1; man_data = 32'h0000_0020;
    step();
    man_valid = 1'b0;
    #1;
    vec++; if (out_valid !== 1'b1 || pc !== 32'h0 || funct !== 6'h20) begin errs++; $display("FAIL rm_refetch: got %b/%h/%h expected 1/00000000/20", out_valid, pc, funct); end
  endtask

  task automatic test_redirect_coincident();
    apply_reset();
    step();
    man_valid = 1'b1; man_data = 32'h0000_0020;
    step();
    man_valid = 1'b0;
    step();
    man_valid = 1'b1; man_data = 32'h2001_0005;
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    #1;
    vec++; if (out_valid !== 1'b1 || imem_req !== 1'b0) begin errs++; $display("FAIL rc_pre: got %b/%b expected 1/0", out_valid, imem_req); end
    step();
    man_valid = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    #1;
    $display("redirect_coincident: out_valid=%b req=%b addr=%h", out_valid, imem_req, imem_addr);
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rc_flush: got %b expected 0", out_valid); end
    vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errs++; $display("FAIL rc_newpc: got %b/%h expected 1/00000300", imem_req, imem_addr); end
    step();
    man_valid = 1'b1; man_data = 32'h2006_0003;
    step();
    man_valid = 1'b0;
    #1;
    vec++; if (out_valid !== 1'b1 || pc !== 32'h300) begin errs++; $display("FAIL rc_deliver: got %b/%h expected 1/00000300", out_valid, pc); end
    vec++; if (rt !== 5'd6 || Adress_Immediate !== 15'h0003) begin errs++; $display("FAIL rc_fields: got %h/%h expected 06/0003", rt, Adress_Immediate); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_halt();
    test_reset_mid_request();
    test_redirect_coincident();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
